// File: rtl/axi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_pkg : shared widths, burst/response codes and FSM states for the AXI
//           memory responder.                                  Rev 1.0
// ---------------------------------------------------------------------------
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Narrow sizes only change the step; FIXED and unsupported bursts hold.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [2:0]        size,
                                                   input logic [1:0]        burst);
    return (burst == BURST_INCR) ? addr + (ADDR_W'(1) << size) : addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_mem_bank : WORDS x 64 storage, asynchronous read, byte-enable write.
//                                                              Rev 1.0
// ---------------------------------------------------------------------------
module axi_mem_bank
  import axi_pkg::*;
#(
  parameter  int WORDS = 65536,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              clock,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  logic [DATA_W-1:0] mem [WORDS];

  assign rd_data = mem[rd_index];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_mem_responder : AXI4 slave backed by a byte-writable memory, with
//                     independent single-outstanding read/write channels. Rev 1.0
// ---------------------------------------------------------------------------
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                MEM_WORDS = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   axi_awid,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [LEN_W-1:0]  axi_awlen,
  input  logic [2:0]        axi_awsize,
  input  logic [1:0]        axi_awburst,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [STRB_W-1:0] axi_wstrb,
  input  logic              axi_wlast,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [ID_W-1:0]   axi_bid,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic [ID_W-1:0]   axi_arid,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [LEN_W-1:0]  axi_arlen,
  input  logic [2:0]        axi_arsize,
  input  logic [1:0]        axi_arburst,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic [ID_W-1:0]   axi_rid,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic              axi_rvalid,
  input  logic              axi_rready
);

  localparam int                IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0]   MEM_BYTES = {1'b0, ADDR_W'(MEM_WORDS)} << 3;

  // ---------------- read channel ----------------
  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;

  logic [ADDR_W-1:0] r_addr_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_burst;
  logic [ADDR_W:0]   rd_off;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_word;

  // One read port serves both the first beat (from AR) and every following beat.
  assign r_addr_next = next_addr(r_addr, r_size, r_burst);
  assign rd_addr     = (r_state == R_IDLE) ? axi_araddr  : r_addr_next;
  assign rd_burst    = (r_state == R_IDLE) ? axi_arburst : r_burst;
  assign rd_off      = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
  assign rd_ok       = !rd_off[ADDR_W] && (rd_off < MEM_BYTES) && burst_ok(rd_burst);
  assign rd_index    = rd_off[IDX_W+2:3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rdata   <= '0;
      axi_rid     <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          axi_arready <= 1'b1;
          if (axi_arvalid && axi_arready) begin
            axi_arready <= 1'b0;
            axi_rid     <= axi_arid;
            r_addr      <= axi_araddr;
            r_len       <= axi_arlen;
            r_size      <= axi_arsize;
            r_burst     <= axi_arburst;
            r_cnt       <= '0;
            axi_rvalid  <= 1'b1;
            axi_rlast   <= (axi_arlen == '0);
            axi_rdata   <= rd_ok ? rd_word : '0;
            axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            if (axi_rlast) begin
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              axi_arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_cnt     <= r_cnt + 1'b1;
              r_addr    <= r_addr_next;
              axi_rlast <= ((r_cnt + 1'b1) == r_len);
              axi_rdata <= rd_ok ? rd_word : '0;
              axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len;
  logic [LEN_W-1:0]  w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;

  logic [ADDR_W:0]   wr_off;
  logic              wr_beat_ok;
  logic              w_fire;
  logic              wr_en;
  logic              wr_err_next;
  logic              wr_done;
  logic [IDX_W-1:0]  wr_index;

  assign wr_off      = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign wr_beat_ok  = !wr_off[ADDR_W] && (wr_off < MEM_BYTES) && burst_ok(w_burst);
  assign wr_index    = wr_off[IDX_W+2:3];
  assign w_fire      = (w_state == W_DATA) && axi_wvalid && axi_wready;
  assign wr_en       = w_fire && wr_beat_ok;
  assign wr_err_next = w_err || !wr_beat_ok || (axi_wlast != (w_cnt == w_len));
  assign wr_done     = axi_wlast || (w_cnt == w_len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      axi_bid     <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          axi_awready <= 1'b1;
          if (axi_awvalid && axi_awready) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            axi_bid     <= axi_awid;
            w_addr      <= axi_awaddr;
            w_len       <= axi_awlen;
            w_size      <= axi_awsize;
            w_burst     <= axi_awburst;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err  <= wr_err_next;
            w_cnt  <= w_cnt + 1'b1;
            w_addr <= next_addr(w_addr, w_size, w_burst);
            if (wr_done) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= wr_err_next ? RESP_SLVERR : RESP_OKAY;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_mem_bank #(
    .WORDS (MEM_WORDS)
  ) u_bank (
    .clock    (clock),
    .rd_index (rd_index),
    .rd_data  (rd_word),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (axi_wdata),
    .wr_strb  (axi_wstrb)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_mem_responder : directed self-checking bench for axi_mem_responder.
//                                                              Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 65536;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  axi_mem_responder #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (WORDS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_arid    (axi_arid),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rid     (axi_rid),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] wbuf     [8];
  logic [63:0] exp_data [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge; beats come from wbuf.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [7:0] strb, input logic [1:0] exp_resp, input string tag);
    int t;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    t = 0;
    while (!axi_awready && t < 20) begin @(negedge clock); t++; end
    if (!axi_awready) begin
      check({tag, "_aw_timeout"}, 0, 1);
      axi_awvalid = 1'b0;
      return;
    end
    @(negedge clock);
    axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      axi_wdata = wbuf[i]; axi_wstrb = strb; axi_wlast = (i == nbeats - 1); axi_wvalid = 1'b1;
      t = 0;
      while (!axi_wready && t < 20) begin @(negedge clock); t++; end
      if (!axi_wready) begin
        check({tag, "_w_timeout"}, 0, 1);
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        return;
      end
      @(negedge clock);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    check({tag, "_bvalid_lat"}, axi_bvalid, 1);
    axi_bready = 1'b1;
    t = 0;
    while (!axi_bvalid && t < 20) begin @(negedge clock); t++; end
    check({tag, "_bresp"}, axi_bresp, exp_resp);
    check({tag, "_bid"}, axi_bid, id);
    @(negedge clock);
    axi_bready = 1'b0;
  endtask

  // Every cycle with rvalid is compared against exp_data[beat], so stalls,
  // lost or duplicated beats all show up. pat gives rready per cycle mod 4.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                         input logic [3:0] pat, input int abort_at, input string tag);
    int t, idx, cyc;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    t = 0;
    while (!axi_arready && t < 20) begin @(negedge clock); t++; end
    if (!axi_arready) begin
      check({tag, "_ar_timeout"}, 0, 1);
      axi_arvalid = 1'b0;
      return;
    end
    @(negedge clock);
    axi_arvalid = 1'b0;
    check({tag, "_rvalid_lat"}, axi_rvalid, 1);
    idx = 0; cyc = 0;
    while (idx <= int'(len) && cyc < 200) begin
      axi_rready = pat[cyc % 4];
      if (axi_rvalid) begin
        if (idx == abort_at) begin
          reset = 1'b1;
          #1;
          check({tag, "_rst_rvalid"}, axi_rvalid, 0);
          check({tag, "_rst_arready"}, axi_arready, 0);
          axi_rready = 1'b0;
          @(negedge clock);
          reset = 1'b0;
          @(negedge clock);
          check({tag, "_rel_arready"}, axi_arready, 1);
          return;
        end
        check($sformatf("%s_rdata%0d", tag, idx), axi_rdata, exp_data[idx]);
        check($sformatf("%s_rresp%0d", tag, idx), axi_rresp, exp_resp);
        check($sformatf("%s_rid%0d", tag, idx), axi_rid, id);
        check($sformatf("%s_rlast%0d", tag, idx), axi_rlast, (idx == int'(len)));
        if (axi_rready) idx++;
      end
      @(negedge clock);
      cyc++;
    end
    axi_rready = 1'b0;
    if (idx <= int'(len)) check({tag, "_r_timeout"}, 0, 1);
    check({tag, "_rvalid_end"}, axi_rvalid, 0);
  endtask

  initial begin
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
    axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0;
    axi_arburst = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_arready", axi_arready, 0);
    check("rst_awready", axi_awready, 0);
    check("rst_rvalid", axi_rvalid, 0);
    check("rst_bvalid", axi_bvalid, 0);
    check("rst_wready", axi_wready, 0);
    check("rst_rdata", axi_rdata, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rel_arready", axi_arready, 1);
    check("rel_awready", axi_awready, 1);

    // words 0..3 = 1..4, words 4..7 = 0x44..0x77
    wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
    do_write(4'd2, BASE, 8'd3, 3'd3, BURST_INCR, 4, 8'hFF, RESP_OKAY, "wr_pre");
    wbuf[0] = 64'h44; wbuf[1] = 64'h55; wbuf[2] = 64'h66; wbuf[3] = 64'h77;
    do_write(4'd3, BASE + 32'h20, 8'd3, 3'd3, BURST_INCR, 4, 8'hFF, RESP_OKAY, "wr_pre2");

    exp_data[0] = 64'd1; exp_data[1] = 64'd2; exp_data[2] = 64'd3; exp_data[3] = 64'd4;
    do_read(4'd5, BASE, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_incr");

    wbuf[0] = '1;
    do_write(4'd6, BASE + 32'h8, 8'd0, 3'd3, BURST_INCR, 1, 8'hFF, RESP_OKAY, "wr_ones");
    wbuf[0] = 64'h1122_3344_5566_7788;
    do_write(4'd7, BASE + 32'h8, 8'd0, 3'd3, BURST_INCR, 1, 8'h0F, RESP_OKAY, "wr_strb");
    exp_data[0] = 64'hFFFF_FFFF_5566_7788;
    do_read(4'd1, BASE + 32'h8, 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_strb");

    exp_data[0] = 64'd1; exp_data[1] = 64'hFFFF_FFFF_5566_7788;
    exp_data[2] = 64'd3; exp_data[3] = 64'd4;
    do_read(4'd9, BASE, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 4'b1001, -1, "rd_bp");

    // The first byte past the end aliases word 0 in the index bits.
    exp_data[0] = 64'd0;
    do_read(4'd4, BASE + 32'(WORDS * 8), 8'd0, 3'd3, BURST_INCR, RESP_SLVERR, 4'b1111, -1, "rd_oor");
    wbuf[0] = 64'hDEAD_BEEF_0BAD_F00D;
    do_write(4'd8, BASE + 32'(WORDS * 8), 8'd0, 3'd3, BURST_INCR, 1, 8'hFF, RESP_SLVERR, "wr_oor");
    exp_data[0] = 64'd1;
    do_read(4'd0, BASE, 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_alias");

    wbuf[0] = 64'hA0; wbuf[1] = 64'hA1;
    do_write(4'd10, BASE + 32'h20, 8'd3, 3'd3, BURST_INCR, 2, 8'hFF, RESP_SLVERR, "wr_early");
    exp_data[0] = 64'hA0; exp_data[1] = 64'hA1; exp_data[2] = 64'h66; exp_data[3] = 64'h77;
    do_read(4'd11, BASE + 32'h20, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_early");

    wbuf[0] = 64'h81; wbuf[1] = 64'h82; wbuf[2] = 64'h83;
    do_write(4'd12, BASE + 32'h40, 8'd2, 3'd3, BURST_FIXED, 3, 8'hFF, RESP_OKAY, "wr_fixed");
    exp_data[0] = 64'h83; exp_data[1] = 64'h83;
    do_read(4'd13, BASE + 32'h40, 8'd1, 3'd3, BURST_FIXED, RESP_OKAY, 4'b1111, -1, "rd_fixed");

    wbuf[0] = 64'h99;
    do_write(4'd14, BASE + 32'h40, 8'd0, 3'd3, BURST_WRAP, 1, 8'hFF, RESP_SLVERR, "wr_wrap");
    exp_data[0] = 64'd0; exp_data[1] = 64'd0;
    do_read(4'd15, BASE + 32'h40, 8'd1, 3'd3, BURST_WRAP, RESP_SLVERR, 4'b1111, -1, "rd_wrap");
    exp_data[0] = 64'h83;
    do_read(4'd1, BASE + 32'h40, 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_after_wrap");

    // 4-byte beats step 0,4,8,C: two beats per word, full word returned.
    exp_data[0] = 64'd1; exp_data[1] = 64'd1;
    exp_data[2] = 64'hFFFF_FFFF_5566_7788; exp_data[3] = 64'hFFFF_FFFF_5566_7788;
    do_read(4'd2, BASE, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_narrow");

    exp_data[0] = 64'd1; exp_data[1] = 64'hFFFF_FFFF_5566_7788;
    do_read(4'd3, BASE, 8'd7, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, 1, "rd_rst");
    exp_data[0] = 64'd1; exp_data[1] = 64'hFFFF_FFFF_5566_7788;
    exp_data[2] = 64'd3; exp_data[3] = 64'd4;
    do_read(4'd5, BASE, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 4'b1111, -1, "rd_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
